multi_lane_deskew: RTL and testbench



---
 rtl/multi_lane_deskew.sv | 161 ++++++++++++++++
 tb/tb_multi_lane_deskew.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lane_deskew.sv
// multi_lane_deskew
//   Bonds LANES byte lanes by locating an alignment marker (ALIGN_K with
//   k_en=1) on every lane, then replaying each lane from its own circular
//   skew buffer so that the markers leave the block in the same cycle.
//
// Ports
//   i_clk_120        sole clock, rising edge
//   i_clk_120_rst    synchronous active-high reset
//   i_lane_cal_done  per-lane calibration done; any 0 forces WAIT_CAL
//   i_lane_k_en      per-lane K flag
//   i_lane_byte      per-lane byte, lane n at [8n+7:8n]
//   i_align_start    single-cycle start/restart request
//   o_k_en, o_byte   deskewed lane data (zero when o_valid is 0)
//   o_valid          output word carries aligned data
//   o_aligned        state is ALIGNED
//   o_align_fail     state is FAIL
//   o_skew_mon       cycles between first and last lane marker
//   o_realign_cnt    alignment losses while ALIGNED, saturating at 255
module multi_lane_deskew #(
    parameter int         LANES    = 4,
    parameter int         DEPTH    = 8,
    parameter logic [7:0] ALIGN_K  = 8'hBC,
    parameter int         MAX_SKEW = DEPTH - 2
) (
    input  logic                     i_clk_120,
    input  logic                     i_clk_120_rst,
    input  logic [LANES-1:0]         i_lane_cal_done,
    input  logic [LANES-1:0]         i_lane_k_en,
    input  logic [8*LANES-1:0]       i_lane_byte,
    input  logic                     i_align_start,
    output logic [LANES-1:0]         o_k_en,
    output logic [8*LANES-1:0]       o_byte,
    output logic                     o_valid,
    output logic                     o_aligned,
    output logic                     o_align_fail,
    output logic [$clog2(DEPTH)-1:0] o_skew_mon,
    output logic [7:0]               o_realign_cnt
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] SKEW_LIM = AW'(MAX_SKEW + 1);

    typedef enum logic [2:0] {IDLE, WAIT_CAL, SEARCH, ALIGNED, FAIL} state_t;

    state_t           state_q, state_d;
    logic [8:0]       mem [LANES][DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr [LANES];
    logic [AW-1:0]    mark [LANES];
    logic [LANES-1:0] flags_q;
    logic [AW-1:0]    timer_q;

    logic [LANES-1:0] in_hit, new_hit, out_hit, flags_nxt;
    logic [AW-1:0]    cur_time;
    logic             all_cal, lose_align, valid_p1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        in_hit  = '0;
        out_hit = '0;
        for (int n = 0; n < LANES; n++) begin
            in_hit[n]  = i_lane_k_en[n] && (i_lane_byte[8*n +: 8] == ALIGN_K);
            out_hit[n] = o_k_en[n] && (o_byte[8*n +: 8] == ALIGN_K);
        end
    end

    assign all_cal    = &i_lane_cal_done;
    assign new_hit    = in_hit & ~flags_q;
    assign flags_nxt  = flags_q | new_hit;
    // The cycle the first marker lands counts as time 0; timer_q already
    // holds the value for the current cycle once some flag is set.
    assign cur_time   = (flags_q == '0) ? '0 : timer_q;
    // Some lanes show the marker and others do not: the bond has slipped.
    assign lose_align = o_valid && (|out_hit) && !(&out_hit);
    assign valid_p1   = (state_q == ALIGNED) && (state_d == ALIGNED);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_align_start) state_d = WAIT_CAL;
            WAIT_CAL: if (all_cal) state_d = SEARCH;
            SEARCH: begin
                if (!all_cal || i_align_start) state_d = WAIT_CAL;
                else if (cur_time >= SKEW_LIM) state_d = FAIL;
                else if (&flags_nxt)           state_d = ALIGNED;
            end
            ALIGNED: begin
                if (!all_cal || i_align_start) state_d = WAIT_CAL;
                else if (lose_align)           state_d = SEARCH;
            end
            FAIL:     if (i_align_start) state_d = WAIT_CAL;
            default:  state_d = IDLE;
        endcase
    end

    // ---- stage p0: skew buffer write (data only, never reset) ----
    always_ff @(posedge i_clk_120) begin
        if (!i_clk_120_rst) begin
            for (int n = 0; n < LANES; n++)
                mem[n][wr_ptr] <= {i_lane_k_en[n], i_lane_byte[8*n +: 8]};
        end
    end

    // ---- stage p1: control state and registered deskewed read ----
    always_ff @(posedge i_clk_120) begin
        if (i_clk_120_rst) begin
            state_q       <= IDLE;
            wr_ptr        <= '0;
            flags_q       <= '0;
            timer_q       <= '0;
            o_valid       <= 1'b0;
            o_k_en        <= '0;
            o_byte        <= '0;
            o_skew_mon    <= '0;
            o_realign_cnt <= '0;
            for (int n = 0; n < LANES; n++) begin
                rd_ptr[n] <= '0;
                mark[n]   <= '0;
            end
        end else begin
            state_q <= state_d;
            wr_ptr  <= wr_ptr + 1'b1;

            if (state_q != SEARCH && state_d == SEARCH) begin
                flags_q <= '0;
                timer_q <= '0;
            end else if (state_q == SEARCH) begin
                flags_q <= flags_nxt;
                if (flags_nxt != '0) timer_q <= cur_time + 1'b1;
                for (int n = 0; n < LANES; n++)
                    if (new_hit[n]) mark[n] <= wr_ptr;
            end

            if (state_q == SEARCH && state_d == ALIGNED) begin
                o_skew_mon <= cur_time;
                // Lanes whose marker arrives this cycle have no stored mark yet.
                for (int n = 0; n < LANES; n++)
                    rd_ptr[n] <= new_hit[n] ? wr_ptr : mark[n];
            end else if (state_q == ALIGNED) begin
                for (int n = 0; n < LANES; n++)
                    rd_ptr[n] <= rd_ptr[n] + 1'b1;
            end

            if (state_q == ALIGNED && state_d == SEARCH)
                o_realign_cnt <= sat_inc(o_realign_cnt);

            o_valid <= valid_p1;
            for (int n = 0; n < LANES; n++) begin
                o_k_en[n]        <= valid_p1 ? mem[n][rd_ptr[n]][8]   : 1'b0;
                o_byte[8*n +: 8] <= valid_p1 ? mem[n][rd_ptr[n]][7:0] : 8'h00;
            end
        end
    end

    assign o_aligned    = (state_q == ALIGNED);
    assign o_align_fail = (state_q == FAIL);

endmodule

// File: tb/tb_multi_lane_deskew.sv
// Directed bench for multi_lane_deskew (LANES=4, DEPTH=8, MAX_SKEW=6).
// Each lane is fed a shared symbol stream delayed by a per-lane offset;
// markers recur every P symbols. Expected aligned words are queued as the
// slowest lane delivers them and compared when o_valid appears.
module tb_multi_lane_deskew;
    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int P     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [LANES-1:0]     cal_done = '1;
    logic [LANES-1:0]     k_en = '0;
    logic [8*LANES-1:0]   lane_byte = '0;
    logic                 align_start = 1'b0;
    logic [LANES-1:0]     o_k_en;
    logic [8*LANES-1:0]   o_byte;
    logic                 o_valid, o_aligned, o_align_fail;
    logic [AW-1:0]        o_skew_mon;
    logic [7:0]           o_realign_cnt;

    int checks = 0;
    int errors = 0;
    int pos = 1;
    int off [LANES];
    int dmax = 0;
    int k0 = P;
    int pops = 0;
    bit push_en = 0, chk_en = 0, no_valid = 0;
    logic [LANES*9-1:0] sb_q [$];
    logic [LANES*9-1:0] mon_exp;

    multi_lane_deskew #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .i_clk_120       (clk),
        .i_clk_120_rst   (rst),
        .i_lane_cal_done (cal_done),
        .i_lane_k_en     (k_en),
        .i_lane_byte     (lane_byte),
        .i_align_start   (align_start),
        .o_k_en          (o_k_en),
        .o_byte          (o_byte),
        .o_valid         (o_valid),
        .o_aligned       (o_aligned),
        .o_align_fail    (o_align_fail),
        .o_skew_mon      (o_skew_mon),
        .o_realign_cnt   (o_realign_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] sym(int i, int n);
        if (i > 0 && i % P == 0) return 9'h1BC;
        return {1'b0, 8'((3*i + 37*n) & 255)};
    endfunction

    function automatic logic [LANES*9-1:0] exp_word(int k);
        logic [LANES-1:0]   kv;
        logic [8*LANES-1:0] bv;
        logic [8:0]         s;
        for (int n = 0; n < LANES; n++) begin
            s = sym(k, n);
            kv[n] = s[8];
            bv[8*n +: 8] = s[7:0];
        end
        return {kv, bv};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step(logic start = 1'b0, logic [LANES-1:0] cal = '1, logic r = 1'b0);
        logic [8:0] s;
        rst = r;
        align_start = start;
        cal_done = cal;
        for (int n = 0; n < LANES; n++) begin
            s = sym(pos - off[n], n);
            k_en[n] = s[8];
            lane_byte[8*n +: 8] = s[7:0];
        end
        if (push_en && (pos - dmax) >= k0) sb_q.push_back(exp_word(pos - dmax));
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic run_to(int last);
        while (pos <= last) step();
    endtask

    task automatic wait_aligned(logic want, string tag);
        int b = 0;
        while (o_aligned !== want && b < 60) begin
            step();
            b++;
        end
        chk(tag, o_aligned, want);
    endtask

    task automatic begin_align(int o0, int o1, int o2, int o3, bit via_reset, bit ok);
        chk_en = 0;
        push_en = 0;
        no_valid = 0;
        sb_q.delete();
        if (via_reset) step(1'b0, '1, 1'b1);
        off[0] = o0; off[1] = o1; off[2] = o2; off[3] = o3;
        dmax = 0;
        for (int n = 0; n < LANES; n++) if (off[n] > dmax) dmax = off[n];
        pos = 1;
        k0 = P;
        pops = 0;
        push_en = ok;
        chk_en = ok;
        no_valid = !ok;
        step(1'b1);
        run_to(P + dmax);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_valid"},   o_valid, 0);
        chk({tag, "_k_en"},    o_k_en, 0);
        chk({tag, "_byte"},    o_byte, 0);
        chk({tag, "_aligned"}, o_aligned, 0);
        chk({tag, "_fail"},    o_align_fail, 0);
        chk({tag, "_skew"},    o_skew_mon, 0);
        chk({tag, "_cnt"},     o_realign_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (no_valid) begin
            checks++;
            assert (o_valid === 1'b0) else begin
                errors++;
                $error("FAIL no_valid observed=%b expected=0", o_valid);
            end
        end else if (chk_en && o_valid === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty observed=valid expected=no_word");
            end
            if (sb_q.size() != 0) begin
                mon_exp = sb_q.pop_front();
                pops++;
                checks++;
                assert ({o_k_en, o_byte} === mon_exp) else begin
                    errors++;
                    $error("FAIL sb_word observed=%h expected=%h", {o_k_en, o_byte}, mon_exp);
                end
            end
        end
    end

    initial begin
        for (int n = 0; n < LANES; n++) off[n] = 0;
        step(1'b0, '1, 1'b1);
        step(1'b0, '1, 1'b1);
        chk_all_zero("reset");

        // Simultaneous markers: skew 0, first word all markers.
        begin_align(0, 0, 0, 0, 1, 1);
        chk("A_aligned", o_aligned, 1);
        chk("A_skew", o_skew_mon, 0);
        step();
        chk("A_first_valid", o_valid, 1);
        chk("A_first_k", o_k_en, 4'hF);
        chk("A_first_byte", o_byte, 32'hBCBCBCBC);
        run_to(40);
        chk("A_still_aligned", o_aligned, 1);
        chk("A_cnt", o_realign_cnt, 0);
        chk("A_pops", pops > 10, 1);

        // Offsets 0/1/3/6: largest tolerated skew.
        begin_align(0, 1, 3, 6, 1, 1);
        chk("B_aligned", o_aligned, 1);
        chk("B_skew", o_skew_mon, 6);
        run_to(60);
        chk("B_still_aligned", o_aligned, 1);
        chk("B_cnt", o_realign_cnt, 0);
        chk("B_pops", pops > 20, 1);

        // Lane 3 seven cycles late: FAIL, no output; restart from FAIL.
        begin_align(0, 0, 0, 7, 1, 0);
        chk("C_fail", o_align_fail, 1);
        chk("C_aligned", o_aligned, 0);
        run_to(40);
        chk("C_fail_hold", o_align_fail, 1);
        begin_align(0, 0, 0, 0, 0, 1);
        chk("C_realigned", o_aligned, 1);
        chk("C_fail_clear", o_align_fail, 0);
        chk("C_skew", o_skew_mon, 0);

        // Shift lane 2 by one cycle while aligned.
        run_to(40);
        chk_en = 0; push_en = 0; sb_q.delete();
        off[2] = 1;
        run_to(50);
        chk("D_lost", o_aligned, 0);
        chk("D_cnt1", o_realign_cnt, 1);
        chk("D_valid0", o_valid, 0);
        dmax = 1; k0 = 4 * P; pops = 0;
        push_en = 1; chk_en = 1;
        run_to(4 * P + 1);
        chk("D_realigned", o_aligned, 1);
        chk("D_skew1", o_skew_mon, 1);
        run_to(80);
        chk("D_pops", pops > 8, 1);

        // Repeated shifts: counter saturates at 255.
        chk_en = 0; push_en = 0; sb_q.delete();
        for (int it = 0; it < 300; it++) begin
            int prev;
            prev = o_realign_cnt;
            off[2] = 1 - off[2];
            wait_aligned(1'b0, "E_loss");
            chk("E_cnt", o_realign_cnt, (prev == 255) ? 255 : prev + 1);
            wait_aligned(1'b1, "E_relock");
        end
        chk("E_cnt_sat", o_realign_cnt, 255);

        // Drop lane 1 calibration while aligned.
        begin
            int b = 0;
            while (pos % P != 4 && b < 20) begin
                step();
                b++;
            end
        end
        chk("F_pre_aligned", o_aligned, 1);
        step(1'b0, 4'b1101);
        chk("F_valid0", o_valid, 0);
        chk("F_aligned0", o_aligned, 0);
        chk("F_fail0", o_align_fail, 0);
        dmax = 0;
        for (int n = 0; n < LANES; n++) if (off[n] > dmax) dmax = off[n];
        k0 = pos - 5 + P;
        pops = 0;
        push_en = 1; chk_en = 1;
        run_to(k0 + dmax);
        chk("F_realigned", o_aligned, 1);
        chk("F_skew", o_skew_mon, dmax);
        run_to(pos + 10);
        chk("F_pops", pops > 5, 1);

        // Reset pulse while aligned.
        chk_en = 0; push_en = 0; sb_q.delete();
        step(1'b0, '1, 1'b1);
        chk_all_zero("G_rst");
        no_valid = 1;
        run_to(pos + 40);
        chk("G_idle", o_aligned, 0);
        no_valid = 0;
        step(1'b1);
        wait_aligned(1'b1, "G_restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
